// File: rtl/cmos_capture_if.sv
// ---------------------------------------------------------------------------
// cmos_capture_if : DVP sensor bus plus packed-pixel output bus
// Optional stats signals appear when CMOS_FRAME_STATS_EN is defined.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface cmos_capture_if;
  logic        cmos_vsync;
  logic        cmos_href;
  logic [7:0]  cmos_data;
  logic [15:0] pix_data;
  logic        pix_valid;
  logic        frame_start;
  logic        frame_end;
  logic        line_end;
  logic        capture_ready;
`ifdef CMOS_FRAME_STATS_EN
  logic [11:0] line_cnt;
  logic [11:0] pix_per_line;
`endif

  // master = sensor/consumer environment, slave = capture block
  modport master (
    output cmos_vsync, cmos_href, cmos_data,
    input  pix_data, pix_valid, frame_start, frame_end, line_end, capture_ready
`ifdef CMOS_FRAME_STATS_EN
    , input line_cnt, pix_per_line
`endif
  );

  modport slave (
    input  cmos_vsync, cmos_href, cmos_data,
    output pix_data, pix_valid, frame_start, frame_end, line_end, capture_ready
`ifdef CMOS_FRAME_STATS_EN
    , output line_cnt, pix_per_line
`endif
  );
endinterface

`default_nettype wire

// File: rtl/cmos_capture.sv
// ---------------------------------------------------------------------------
// cmos_capture : skips FRAME_SKIP frames after config_done, then packs DVP
// bytes into RGB565 pixels with frame/line markers. Macro: CMOS_FRAME_STATS_EN
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module cmos_capture #(
  parameter int FRAME_SKIP = 10
) (
  input  wire logic     clk,
  input  wire logic     rst_n,
  input  wire logic     config_done,
  cmos_capture_if.slave cam
);

  localparam logic [7:0] C_SKIP = 8'(FRAME_SKIP);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SKIP    = 2'd1,
    WAIT_VS = 2'd2,
    CAPTURE = 2'd3
  } state_t;

  state_t      state, state_next;
  logic [7:0]  r_skip_cnt, skip_next;
  logic        r_cfg_meta, r_cfg_sync;
  logic        r_vs, r_hs, r_vs_d, r_hs_d;
  logic [7:0]  r_data;
  logic        r_toggle;
  logic [7:0]  r_hi;
  logic [15:0] r_pix_data;
  logic        r_pix_valid, r_frame_start, r_frame_end, r_line_end, r_capture_ready;

  logic w_vs_fall, w_vs_rise, w_hs_fall;
  logic w_capturing, w_pack, w_strobe, w_line_end;
  logic w_frame_start, w_frame_end;

  assign w_vs_fall   = r_vs_d & ~r_vs;
  assign w_vs_rise   = ~r_vs_d & r_vs;
  assign w_hs_fall   = r_hs_d & ~r_hs;
  // Everything downstream is gated by cfg_sync so a config drop stops output
  // in the same cycle the state machine heads back to IDLE.
  assign w_capturing = r_cfg_sync && (state == CAPTURE);
  assign w_pack      = w_capturing && r_hs && !r_vs;
  assign w_strobe    = w_pack && r_toggle;
  assign w_line_end  = w_capturing && w_hs_fall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cfg_meta <= 1'b0;
      r_cfg_sync <= 1'b0;
      r_vs       <= 1'b0;
      r_hs       <= 1'b0;
      r_data     <= 8'd0;
      r_vs_d     <= 1'b0;
      r_hs_d     <= 1'b0;
    end else begin
      r_cfg_meta <= config_done;
      r_cfg_sync <= r_cfg_meta;
      r_vs       <= cam.cmos_vsync;
      r_hs       <= cam.cmos_href;
      r_data     <= cam.cmos_data;
      r_vs_d     <= r_vs;
      r_hs_d     <= r_hs;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      r_skip_cnt <= 8'd0;
    end else begin
      state      <= state_next;
      r_skip_cnt <= skip_next;
    end
  end

  always_comb begin
    state_next    = state;
    skip_next     = r_skip_cnt;
    w_frame_start = 1'b0;
    w_frame_end   = 1'b0;
    if (!r_cfg_sync) begin
      state_next = IDLE;
      skip_next  = 8'd0;
    end else begin
      case (state)
        IDLE: begin
          skip_next  = 8'd0;
          state_next = (C_SKIP == 8'd0) ? WAIT_VS : SKIP;
        end
        SKIP: begin
          if (w_vs_fall) begin
            if (r_skip_cnt + 8'd1 == C_SKIP) begin
              state_next = WAIT_VS;
              skip_next  = 8'd0;
            end else begin
              skip_next = r_skip_cnt + 8'd1;
            end
          end
        end
        WAIT_VS: begin
          if (w_vs_fall) begin
            state_next    = CAPTURE;
            w_frame_start = 1'b1;
          end
        end
        CAPTURE: begin
          if (w_vs_rise) begin
            state_next  = WAIT_VS;
            w_frame_end = 1'b1;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_toggle        <= 1'b0;
      r_hi            <= 8'd0;
      r_pix_data      <= 16'd0;
      r_pix_valid     <= 1'b0;
      r_frame_start   <= 1'b0;
      r_frame_end     <= 1'b0;
      r_line_end      <= 1'b0;
      r_capture_ready <= 1'b0;
    end else begin
      r_toggle <= w_pack ? ~r_toggle : 1'b0;
      if (w_pack && !r_toggle) begin
        r_hi <= r_data;
      end
      if (w_strobe) begin
        r_pix_data <= {r_hi, r_data};
      end
      r_pix_valid     <= w_strobe;
      r_frame_start   <= w_frame_start;
      r_frame_end     <= w_frame_end;
      r_line_end      <= w_line_end;
      r_capture_ready <= (state == WAIT_VS) || (state == CAPTURE);
    end
  end

  assign cam.pix_data      = r_pix_data;
  assign cam.pix_valid     = r_pix_valid;
  assign cam.frame_start   = r_frame_start;
  assign cam.frame_end     = r_frame_end;
  assign cam.line_end      = r_line_end;
  assign cam.capture_ready = r_capture_ready;

`ifdef CMOS_FRAME_STATS_EN
  logic [11:0] r_line_run, r_pix_run, r_pix_last;
  logic [11:0] r_line_cnt, r_pix_per_line;
  logic [11:0] w_line_inc, w_pix_inc;

  assign w_line_inc = (r_line_run == 12'hFFF) ? r_line_run : r_line_run + 12'd1;
  assign w_pix_inc  = (r_pix_run == 12'hFFF) ? r_pix_run : r_pix_run + 12'd1;

  // A line_end coinciding with frame_end must still be folded into the result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_line_run     <= 12'd0;
      r_pix_run      <= 12'd0;
      r_pix_last     <= 12'd0;
      r_line_cnt     <= 12'd0;
      r_pix_per_line <= 12'd0;
    end else begin
      if (w_frame_start) begin
        r_line_run <= 12'd0;
        r_pix_run  <= 12'd0;
        r_pix_last <= 12'd0;
      end else if (w_line_end) begin
        r_line_run <= w_line_inc;
        r_pix_last <= r_pix_run;
        r_pix_run  <= 12'd0;
      end else if (w_strobe) begin
        r_pix_run <= w_pix_inc;
      end
      if (w_frame_end) begin
        r_line_cnt     <= w_line_end ? w_line_inc : r_line_run;
        r_pix_per_line <= w_line_end ? r_pix_run : r_pix_last;
      end
    end
  end

  assign cam.line_cnt     = r_line_cnt;
  assign cam.pix_per_line = r_pix_per_line;
`endif

endmodule

`default_nettype wire

// File: tb/tb_cmos_capture.sv
// ---------------------------------------------------------------------------
// tb_cmos_capture : scoreboard bench for cmos_capture (FRAME_SKIP=2)
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_cmos_capture;
  localparam int FRAME_SKIP = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic config_done = 1'b0;

  cmos_capture_if cam();

  cmos_capture #(.FRAME_SKIP(FRAME_SKIP)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .config_done(config_done),
    .cam(cam)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int n_pv = 0, n_fs = 0, n_fe = 0, n_le = 0;
  int last_pv_cyc = 0, last_byte_cyc = 0, pv_gap = 0, le_gap = 0;
  logic [15:0] exp_q[$];
  logic [7:0]  line_bytes[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Pixel scoreboard and marker counters, sampled mid-cycle
  always @(negedge clk) begin
    if (rst_n) begin
      if (cam.pix_valid) begin
        n_pv++;
        pv_gap = cyc - last_byte_cyc;
        last_pv_cyc = cyc;
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL pix_unexpected got=%h expected=none", cam.pix_data);
        end else begin
          logic [15:0] e;
          e = exp_q.pop_front();
          if (cam.pix_data !== e) begin
            failures++;
            $display("FAIL pix_data got=%h expected=%h", cam.pix_data, e);
          end
        end
      end
      if (cam.line_end) begin
        n_le++;
        le_gap = cyc - last_pv_cyc;
      end
      if (cam.frame_start) n_fs++;
      if (cam.frame_end) n_fe++;
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_line(input bit cap);
    for (int i = 0; i < line_bytes.size(); i++) begin
      cam.cmos_href = 1'b1;
      cam.cmos_data = line_bytes[i];
      last_byte_cyc = cyc;
      if (cap && (i % 2 == 1)) exp_q.push_back({line_bytes[i-1], line_bytes[i]});
      tick();
    end
    cam.cmos_href = 1'b0;
    cam.cmos_data = 8'h00;
    repeat (4) tick();
  endtask

  task automatic send_frame(input int nlines, input bit cap);
    cam.cmos_vsync = 1'b1;
    repeat (4) tick();
    cam.cmos_vsync = 1'b0;
    repeat (3) tick();
    repeat (nlines) drive_line(cap);
  endtask

  task automatic vblank();
    cam.cmos_vsync = 1'b1;
    repeat (6) tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    config_done = 1'b0;
    cam.cmos_vsync = 1'b1;
    cam.cmos_href = 1'b0;
    cam.cmos_data = 8'h00;
    repeat (3) tick();
    checks++;
    if ({cam.pix_valid, cam.frame_start, cam.frame_end, cam.line_end, cam.capture_ready} !== 5'b0) begin
      failures++;
      $display("FAIL reset_strobes got=%b expected=00000",
               {cam.pix_valid, cam.frame_start, cam.frame_end, cam.line_end, cam.capture_ready});
    end
    checks++;
    if (cam.pix_data !== 16'h0000) begin
      failures++;
      $display("FAIL reset_pix_data got=%h expected=0000", cam.pix_data);
    end
    rst_n = 1'b1;
    repeat (2) tick();
  endtask

  task automatic test_skip_and_capture();
    int fs0, fe0, le0, pv0;
    fs0 = n_fs; fe0 = n_fe; le0 = n_le; pv0 = n_pv;
    line_bytes = '{8'h01, 8'h02, 8'h03, 8'h04};
    config_done = 1'b1;
    repeat (4) tick();
    checks++;
    if (cam.capture_ready !== 1'b0) begin
      failures++;
      $display("FAIL skip_ready got=%b expected=0", cam.capture_ready);
    end
    send_frame(3, 1'b0);
    send_frame(3, 1'b0);
    checks++;
    if (n_fs - fs0 !== 0 || n_pv - pv0 !== 0 || n_le - le0 !== 0) begin
      failures++;
      $display("FAIL skipped_frames got=fs%0d/pv%0d/le%0d expected=0/0/0", n_fs - fs0, n_pv - pv0, n_le - le0);
    end
    checks++;
    if (cam.capture_ready !== 1'b1) begin
      failures++;
      $display("FAIL wait_ready got=%b expected=1", cam.capture_ready);
    end
    send_frame(3, 1'b1);
    send_frame(3, 1'b1);
    vblank();
    checks++;
    if (n_fs - fs0 !== 2 || n_fe - fe0 !== 2) begin
      failures++;
      $display("FAIL frame_markers got=fs%0d/fe%0d expected=2/2", n_fs - fs0, n_fe - fe0);
    end
    checks++;
    if (n_le - le0 !== 6 || n_pv - pv0 !== 12) begin
      failures++;
      $display("FAIL line_pixel_counts got=le%0d/pv%0d expected=6/12", n_le - le0, n_pv - pv0);
    end
  endtask

  task automatic test_pixel_latency();
    int pv0;
    pv0 = n_pv;
    line_bytes = '{8'hF8, 8'h1F};
    send_frame(1, 1'b1);
    vblank();
    checks++;
    if (n_pv - pv0 !== 1 || pv_gap !== 2) begin
      failures++;
      $display("FAIL pix_latency got=pv%0d/gap%0d expected=1/2", n_pv - pv0, pv_gap);
    end
    checks++;
    if (le_gap !== 1) begin
      failures++;
      $display("FAIL line_end_gap got=%0d expected=1", le_gap);
    end
    checks++;
    if (cam.pix_data !== 16'hF81F) begin
      failures++;
      $display("FAIL pix_hold got=%h expected=f81f", cam.pix_data);
    end
  endtask

  task automatic test_odd_bytes();
    int pv0, le0;
    pv0 = n_pv; le0 = n_le;
    line_bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    send_frame(1, 1'b1);
    vblank();
    checks++;
    if (n_pv - pv0 !== 2 || n_le - le0 !== 1 || le_gap < 1) begin
      failures++;
      $display("FAIL odd_line got=pv%0d/le%0d/gap%0d expected=2/1/>=1", n_pv - pv0, n_le - le0, le_gap);
    end
    checks++;
    if (cam.pix_data !== 16'h3344) begin
      failures++;
      $display("FAIL odd_last_pixel got=%h expected=3344", cam.pix_data);
    end
  endtask

  task automatic test_config_drop();
    int pv0, fe0, fs0, drop_cyc;
    pv0 = n_pv; fe0 = n_fe;
    line_bytes = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'hA6, 8'hA7};
    send_frame(1, 1'b1);
    drop_cyc = 0;
    for (int i = 0; i < 8; i++) begin
      cam.cmos_href = 1'b1;
      cam.cmos_data = line_bytes[i];
      last_byte_cyc = cyc;
      if (i == 4) begin
        config_done = 1'b0;
        drop_cyc = cyc;
      end
      if (i == 1 || i == 3) exp_q.push_back({line_bytes[i-1], line_bytes[i]});
      tick();
    end
    cam.cmos_href = 1'b0;
    repeat (4) tick();
    checks++;
    if (cam.capture_ready !== 1'b0) begin
      failures++;
      $display("FAIL drop_ready got=%b expected=0", cam.capture_ready);
    end
    drive_line(1'b0);
    vblank();
    checks++;
    if (n_pv - pv0 !== 6 || last_pv_cyc - drop_cyc > 3) begin
      failures++;
      $display("FAIL drop_pixels got=pv%0d/lag%0d expected=6/<=3", n_pv - pv0, last_pv_cyc - drop_cyc);
    end
    checks++;
    if (n_fe - fe0 !== 0) begin
      failures++;
      $display("FAIL drop_frame_end got=%0d expected=0", n_fe - fe0);
    end
    config_done = 1'b1;
    repeat (4) tick();
    fs0 = n_fs;
    line_bytes = '{8'h5A, 8'hC3};
    send_frame(1, 1'b0);
    send_frame(1, 1'b0);
    checks++;
    if (n_fs - fs0 !== 0) begin
      failures++;
      $display("FAIL reskip got=%0d expected=0", n_fs - fs0);
    end
    send_frame(1, 1'b1);
    vblank();
    checks++;
    if (n_fs - fs0 !== 1) begin
      failures++;
      $display("FAIL recapture got=%0d expected=1", n_fs - fs0);
    end
  endtask

  task automatic test_async_reset();
    int pv0, fe0;
    line_bytes = '{8'h01, 8'h02, 8'h03, 8'h04};
    send_frame(1, 1'b1);
    checks++;
    if (cam.capture_ready !== 1'b1) begin
      failures++;
      $display("FAIL pre_reset_ready got=%b expected=1", cam.capture_ready);
    end
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({cam.pix_valid, cam.frame_start, cam.frame_end, cam.line_end, cam.capture_ready} !== 5'b0
        || cam.pix_data !== 16'h0000) begin
      failures++;
      $display("FAIL async_reset got=%b/%h expected=00000/0000",
               {cam.pix_valid, cam.frame_start, cam.frame_end, cam.line_end, cam.capture_ready}, cam.pix_data);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    pv0 = n_pv; fe0 = n_fe;
    drive_line(1'b0);
    drive_line(1'b0);
    vblank();
    checks++;
    if (n_pv - pv0 !== 0 || n_fe - fe0 !== 0 || cam.capture_ready !== 1'b0) begin
      failures++;
      $display("FAIL post_reset got=pv%0d/fe%0d/rdy%b expected=0/0/0", n_pv - pv0, n_fe - fe0, cam.capture_ready);
    end
  endtask

`ifdef CMOS_FRAME_STATS_EN
  task automatic test_stats();
    line_bytes = '{8'h10, 8'h20};
    send_frame(1, 1'b0);
    send_frame(1, 1'b0);
    line_bytes = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    send_frame(5, 1'b1);
    vblank();
    checks++;
    if (cam.line_cnt !== 12'd5 || cam.pix_per_line !== 12'd4) begin
      failures++;
      $display("FAIL frame_stats got=%0d/%0d expected=5/4", cam.line_cnt, cam.pix_per_line);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_skip_and_capture();
    test_pixel_latency();
    test_odd_bytes();
    test_config_drop();
    test_async_reset();
`ifdef CMOS_FRAME_STATS_EN
    test_stats();
`endif
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain got=%0d expected=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
